// File: rtl/wide_add_pkg.sv
// Shared types and constants for the multi-word add/subtract sequencer.
package wide_add_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// Sixteen-bit full adder slice shared by the sequencer across all beats.
module SixTeenBitFullAdder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    assign sum   = total[15:0];
    assign cout  = total[16];

endmodule

// File: rtl/wide_add_sequencer.sv
// W-bit add/subtract built from one 16-bit adder, stepped LS slice first with a registered carry.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*WORDS-1:0] op_a,
    input  logic [SLICE_W*WORDS-1:0] op_b,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*WORDS-1:0] result,
    output logic                     carry_out,
    output logic                     overflow,
    output logic                     busy
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    assign a_slice = a_q[idx_q*SLICE_W +: SLICE_W];
    assign b_slice = b_q[idx_q*SLICE_W +: SLICE_W];

    SixTeenBitFullAdder u_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // b is stored already inverted for subtraction, so the top slice MSBs give the signed overflow test.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    carry_out_d = slice_cout;
                    overflow_d  = (a_slice[SLICE_W-1] == b_slice[SLICE_W-1]) &&
                                  (slice_sum[SLICE_W-1] != a_slice[SLICE_W-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset window.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer, covering WORDS = 4 and WORDS = 1.
module tb_wide_add_sequencer;

    typedef struct {
        logic [63:0] res;
        logic        co;
        logic        ov;
    } exp4_t;

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        ov;
    } exp1_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid4 = 1'b0, out_ready4 = 1'b0, sub4 = 1'b0;
    logic [63:0] op_a4 = '0, op_b4 = '0;
    logic        in_ready4, out_valid4, carry_out4, overflow4, busy4;
    logic [63:0] result4;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b0, sub1 = 1'b0;
    logic [15:0] op_a1 = '0, op_b1 = '0;
    logic        in_ready1, out_valid1, carry_out1, overflow1, busy1;
    logic [15:0] result1;

    exp4_t sb4[$];
    exp1_t sb1[$];
    int    n_checks = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .op_a(op_a4), .op_b(op_b4), .sub(sub4), .out_valid(out_valid4),
        .out_ready(out_ready4), .result(result4), .carry_out(carry_out4),
        .overflow(overflow4), .busy(busy4)
    );

    wide_add_sequencer #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .result(result1), .carry_out(carry_out1),
        .overflow(overflow1), .busy(busy1)
    );

    function automatic exp4_t mk4(input logic [63:0] r, input logic c, input logic v);
        exp4_t e;
        e.res = r;
        e.co  = c;
        e.ov  = v;
        return e;
    endfunction

    function automatic exp1_t mk1(input logic [15:0] r, input logic c, input logic v);
        exp1_t e;
        e.res = r;
        e.co  = c;
        e.ov  = v;
        return e;
    endfunction

    // Reference model for random operands: one full-width addition.
    function automatic exp4_t model4(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic [63:0] be;
        logic [64:0] t;
        exp4_t       e;
        be    = s ? ~b : b;
        t     = {1'b0, a} + {1'b0, be} + {64'b0, s};
        e.res = t[63:0];
        e.co  = t[64];
        e.ov  = (a[63] == be[63]) && (t[63] != a[63]);
        return e;
    endfunction

    task automatic run_op4(input logic [63:0] a, input logic [63:0] b, input logic s,
                           input exp4_t e, input int hold);
        exp4_t       got;
        int          lat;
        int          guard;
        logic [63:0] snap;
        @(negedge clk);
        op_a4 = a;
        op_b4 = b;
        sub4 = s;
        in_valid4 = 1'b1;
        guard = 0;
        while (!in_ready4 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (in_ready4 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL accept4: in_ready=%b required 1", in_ready4);
        end
        @(posedge clk);
        sb4.push_back(e);
        @(negedge clk);
        in_valid4 = 1'b0;
        op_a4 = {$urandom, $urandom};
        op_b4 = {$urandom, $urandom};
        sub4 = ~s;
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("[TB] FAIL latency4: got %0d cycles required 4", lat);
        end
        snap = result4;
        for (int i = 0; i < hold; i++) begin
            in_valid4 = 1'b1;
            op_a4 = {$urandom, $urandom};
            op_b4 = {$urandom, $urandom};
            n_checks++;
            if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || result4 !== snap) begin
                n_fail++;
                $display("[TB] FAIL hold4[%0d]: out_valid=%b in_ready=%b result=%h required 1 0 %h",
                         i, out_valid4, in_ready4, result4, snap);
            end
            @(negedge clk);
        end
        in_valid4 = (hold > 0);
        out_ready4 = 1'b1;
        n_checks++;
        if (sb4.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard4: output with empty queue");
        end else begin
            got = sb4.pop_front();
            if (out_valid4 !== 1'b1 || result4 !== got.res || carry_out4 !== got.co ||
                overflow4 !== got.ov) begin
                n_fail++;
                $display("[TB] FAIL result4: valid=%b result=%h co=%b ov=%b required 1 %h %b %b",
                         out_valid4, result4, carry_out4, overflow4, got.res, got.co, got.ov);
            end
        end
        @(posedge clk);
        @(negedge clk);
        out_ready4 = 1'b0;
        in_valid4 = 1'b0;
        n_checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL release4: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     out_valid4, in_ready4, busy4);
        end
    endtask

    task automatic run_op1(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input exp1_t e);
        exp1_t got;
        int    lat;
        @(negedge clk);
        op_a1 = a;
        op_b1 = b;
        sub1 = s;
        in_valid1 = 1'b1;
        n_checks++;
        if (in_ready1 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL accept1: in_ready=%b required 1", in_ready1);
        end
        @(posedge clk);
        sb1.push_back(e);
        @(negedge clk);
        in_valid1 = 1'b0;
        op_a1 = 16'($urandom);
        lat = 0;
        while (!out_valid1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("[TB] FAIL latency1: got %0d cycles required 1", lat);
        end
        out_ready1 = 1'b1;
        n_checks++;
        if (sb1.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard1: output with empty queue");
        end else begin
            got = sb1.pop_front();
            if (result1 !== got.res || carry_out1 !== got.co || overflow1 !== got.ov) begin
                n_fail++;
                $display("[TB] FAIL result1: result=%h co=%b ov=%b required %h %b %b",
                         result1, carry_out1, overflow1, got.res, got.co, got.ov);
            end
        end
        @(posedge clk);
        @(negedge clk);
        out_ready1 = 1'b0;
        n_checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL release1: out_valid=%b in_ready=%b required 0 1",
                     out_valid1, in_ready1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (in_ready4 !== 1'b0 || out_valid4 !== 1'b0 || result4 !== 64'h0 ||
            carry_out4 !== 1'b0 || overflow4 !== 1'b0 || busy4 !== 1'b0 || in_ready1 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: rdy=%b vld=%b res=%h co=%b ov=%b busy=%b rdy1=%b required all 0",
                     in_ready4, out_valid4, result4, carry_out4, overflow4, busy4, in_ready1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready4 !== 1'b1 || busy4 !== 1'b0 || out_valid4 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: in_ready=%b busy=%b out_valid=%b required 1 0 0",
                     in_ready4, busy4, out_valid4);
        end
    endtask

    task automatic test_add_basic();
        run_op4(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, mk4(64'h0000_0000_0001_0000, 1'b0, 1'b0), 0);
    endtask

    task automatic test_carry_ripple();
        run_op4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, mk4(64'h0, 1'b1, 1'b0), 0);
    endtask

    task automatic test_signed_overflow();
        run_op4(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, mk4(64'h8000_0000_0000_0000, 1'b0, 1'b1), 0);
    endtask

    task automatic test_subtract();
        run_op4(64'd5, 64'd7, 1'b1, mk4(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0), 0);
        run_op4(64'd7, 64'd5, 1'b1, mk4(64'd2, 1'b1, 1'b0), 0);
    endtask

    task automatic test_hold_done();
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        run_op4(a, b, 1'b0, model4(a, b, 1'b0), 10);
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b;
        logic        s;
        for (int i = 0; i < 6; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            s = i[0];
            run_op4(a, b, s, model4(a, b, s), 0);
        end
    endtask

    task automatic test_reset_mid_run();
        int stray;
        @(negedge clk);
        op_a4 = 64'hDEAD_BEEF_CAFE_F00D;
        op_b4 = 64'h0123_4567_89AB_CDEF;
        sub4 = 1'b0;
        in_valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready4 !== 1'b0 || out_valid4 !== 1'b0 || result4 !== 64'h0 ||
            carry_out4 !== 1'b0 || overflow4 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_outputs: rdy=%b vld=%b res=%h co=%b ov=%b busy=%b required all 0",
                     in_ready4, out_valid4, result4, carry_out4, overflow4, busy4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready4 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL abort_ready: in_ready=%b required 1", in_ready4);
        end
        stray = 0;
        out_ready4 = 1'b1;
        repeat (6) begin
            if (out_valid4 !== 1'b0) stray++;
            @(negedge clk);
        end
        out_ready4 = 1'b0;
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_valid: %0d stray out_valid cycles required 0", stray);
        end
        run_op4(64'h1234, 64'h1, 1'b0, mk4(64'h1235, 1'b0, 1'b0), 0);
    endtask

    task automatic test_words1();
        run_op1(16'hFFFF, 16'h0001, 1'b0, mk1(16'h0000, 1'b1, 1'b0));
        run_op1(16'h7FFF, 16'h0001, 1'b0, mk1(16'h8000, 1'b0, 1'b1));
        run_op1(16'h0005, 16'h0007, 1'b1, mk1(16'hFFFE, 1'b0, 1'b0));
        run_op1(16'h0007, 16'h0005, 1'b1, mk1(16'h0002, 1'b1, 1'b0));
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_carry_ripple();
        test_signed_overflow();
        test_subtract();
        test_hold_done();
        test_back_to_back();
        test_reset_mid_run();
        test_words1();
        n_checks++;
        if (sb4.size() != 0 || sb1.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: %0d/%0d entries left required 0", sb4.size(), sb1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-word adder/subtractor that sequences one shared 16-bit ripple adder over WORDS slices, least-significant slice first, with a registered carry between beats. It sits between an operand producer and a result consumer, with valid/ready on both sides. It gives W-bit addition and subtraction at the cost of one adder plus registers.

## Interface

Parameters:
- WORDS, default 4: number of 16-bit slices; legal range ≥1; operand width W = 16*WORDS.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept an operation
- op_a  in  W  operand A
- op_b  in  W  operand B
- sub  in  1  0 = A+B, 1 = A−B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- result  out  W  sum/difference
- carry_out  out  1  final carry; for sub, 1 = no borrow (A ≥ B unsigned)
- overflow  out  1  two's-complement signed overflow
- busy  out  1  high in RUN or DONE

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready at a rising edge:
    - capture op_a into a_reg.
    - capture b_reg = sub ? ~op_b : op_b.
    - set carry_reg = sub and slice index idx = 0.
    - go to RUN.
- RUN
  - Adder inputs: a_reg[idx], b_reg[idx], carry_reg.
  - Each edge: write the sum into result slice idx, carry_reg <= adder carry, idx++.
  - On the edge where idx == WORDS−1:
    - carry_out <= adder carry.
    - overflow <= (a_msb == b_eff_msb) & (sum_msb != a_msb).
    - go to DONE.
- DONE
  - out_valid = 1; result, carry_out and overflow are held stable.
  - On out_valid & out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. in_valid is ignored there; the operand bus may change freely after acceptance.
- Reset values:
  - All outputs 0 while rst_n is low (in_ready forced 0).
  - State IDLE; result, carry_out, overflow, a_reg, b_reg, carry_reg and idx all 0.
- Reset mid-operation aborts immediately. No out_valid is produced for the aborted operation.
- The slice index is $clog2(WORDS) bits wide, minimum 1 bit. It never wraps past WORDS−1.
- WORDS = 1: RUN lasts a single cycle.

## Timing

- Accept edge E0. Slices are written on edges E1..E_WORDS. out_valid is high after edge E_WORDS, so latency is WORDS cycles.
- The earliest result handshake is at E_WORDS+1. IDLE is re-entered then, and the next accept is at E_WORDS+2. Peak throughput is one operation per WORDS+2 cycles.
- Partial slices in result are internal only. The result is valid exactly when out_valid = 1.
- All outputs are registered except in_ready and busy, which decode directly from state.

## Structure

- Shared package wide_add_pkg holds:
  - state typedef: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
  - SLICE_W = 16.
- One sub-module: a single instance of the team's existing SixTeenBitFullAdder, driven by slice muxes. No other arithmetic is allowed in the block.

## Test plan

Scenarios 1–5 use WORDS = 4.

1. Add 0x0000_0000_0000_FFFF + 1, sub = 0 -> result 0x0000_0000_0001_0000, carry_out 0, overflow 0, out_valid exactly 4 cycles after accept.
2. Add 0xFFFF_FFFF_FFFF_FFFF + 1 -> result 0, carry_out 1, overflow 0 (carry ripples through all slices).
3. Add 0x7FFF_FFFF_FFFF_FFFF + 1 -> result 0x8000_0000_0000_0000, overflow 1, carry_out 0.
4. Subtract 5 − 7 -> result 0xFFFF_FFFF_FFFF_FFFE, carry_out 0, overflow 0. Subtract 7 − 5 -> result 2, carry_out 1.
5. Hold out_ready low for 10 cycles in DONE:
   - Required: result stable, out_valid held, in_ready 0, and a concurrent in_valid with new operands ignored.
   - After out_ready rises, the next accept occurs no earlier than 2 edges after the handshake.
6. Drop rst_n during RUN at idx = 2 -> all outputs 0 immediately. After release: in_ready = 1, no spurious out_valid, and the next operation (0x1234 + 0x1) returns 0x1235. Repeat scenarios 1–2 with WORDS = 1 (0xFFFF + 1 -> result 0, carry_out 1, latency 1 cycle).
